// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared widths and payload types for the SRAM RW port controller
package sram_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int NUM_WMASKS = DATA_W / 8;
  localparam int TAG_W = 4;
  localparam int RSP_DEPTH = 4;
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [TAG_W-1:0]  tag;
  } rsp_t;
  typedef struct packed {
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [NUM_WMASKS-1:0] be;
    logic [TAG_W-1:0]      tag;
  } req_t;
endpackage

// File: rtl/sram_rw_port_ctrl_if.sv
// sram_rw_port_ctrl_if: request/response handshake bundle for the SRAM RW port
interface sram_rw_port_ctrl_if;
  import sram_ctrl_pkg::*;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [NUM_WMASKS-1:0] req_be;
  logic [TAG_W-1:0]      req_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic [TAG_W-1:0]      rsp_tag;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_tag
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_tag
  );
endinterface

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: ordered read-response FIFO with occupancy count
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  rsp_t        push_data,
  output logic        pop_valid,
  input  logic        pop_ready,
  output rsp_t        pop_data,
  output logic [AW:0] count
);
  rsp_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop;
  assign pop_valid = count != '0;
  assign pop = pop_valid & pop_ready;
  assign pop_data = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/sram_rw_port_ctrl.sv
// sram_rw_port_ctrl: drives SRAM port 0 from a req handshake, queues read data as tagged responses
module sram_rw_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DEPTH = RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_rw_port_ctrl_if.slave    bus,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_W-1:0]     sram_addr0,
  output logic [DATA_W-1:0]     sram_din0,
  input  logic [DATA_W-1:0]     sram_dout0
);
  localparam int CW = $clog2(DEPTH) + 1;
  req_t req;
  rsp_t push_data, pop_data;
  logic s1, fire;
  logic [TAG_W-1:0] s1_tag;
  logic [CW-1:0] count;
  assign req = {bus.req_we, bus.req_addr, bus.req_wdata, bus.req_be, bus.req_tag};
  // a read needs a free FIFO slot counting the one already in flight; same-cycle pops are ignored
  assign bus.req_ready = rst_n & (req.we | (({1'b0, count} + (CW+1)'(s1)) < (CW+1)'(DEPTH)));
  assign fire = bus.req_valid & bus.req_ready;
  assign sram_csb0 = !fire;
  assign sram_web0 = !req.we;
  assign sram_wmask0 = req.be;
  assign sram_addr0 = req.addr;
  assign sram_din0 = req.wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1     <= 1'b0;
      s1_tag <= '0;
    end else begin
      s1     <= fire & !req.we;
      s1_tag <= req.tag;
    end
  assign push_data = '{rdata: sram_dout0, tag: s1_tag};
  sram_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (s1),
    .push_data(push_data),
    .pop_valid(bus.rsp_valid),
    .pop_ready(bus.rsp_ready),
    .pop_data (pop_data),
    .count    (count)
  );
  assign bus.rsp_rdata = pop_data.rdata;
  assign bus.rsp_tag = pop_data.tag;
endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// tb_sram_rw_port_ctrl: directed scoreboard bench with a behavioural 1RW SRAM port model
module tb_sram_rw_port_ctrl;
  import sram_ctrl_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  logic csb, web;
  logic [3:0] wmask;
  logic [7:0] addr;
  logic [31:0] din, dout;
  int total = 0, passed = 0, cyc = 0;
  rsp_t exp_q[$];
  sram_rw_port_ctrl_if bus();
  sram_rw_port_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .sram_csb0(csb), .sram_web0(web), .sram_wmask0(wmask),
    .sram_addr0(addr), .sram_din0(din), .sram_dout0(dout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // SRAM: sample at posedge, write or drive dout at the following negedge
  logic [31:0] mem [256];
  logic l_csb = 1, l_web = 1;
  logic [3:0] l_mask;
  logic [7:0] l_addr;
  logic [31:0] l_din;
  initial for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
  always @(posedge clk) begin
    l_csb = csb; l_web = web; l_mask = wmask; l_addr = addr; l_din = din;
  end
  always @(negedge clk)
    if (!l_csb) begin
      if (!l_web) begin
        for (int b = 0; b < 4; b++) if (l_mask[b]) mem[l_addr][8*b +: 8] = l_din[8*b +: 8];
      end else dout = mem[l_addr];
    end
  function automatic logic [31:0] init_val(input int a);
    return 32'hC0DE0000 | a;
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  always @(negedge clk)
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      rsp_t e;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_rsp: got data %0h tag %0d expected none", bus.rsp_rdata, bus.rsp_tag);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_tag", bus.rsp_tag, e.tag);
      end
    end
  always @(posedge clk)
    if (rst_n && dut.s1 && dut.count == 3'd4 && !(bus.rsp_valid && bus.rsp_ready)) begin
      total++;
      $display("FAIL fifo_overflow: push with count %0d expected < 4", dut.count);
    end
  task automatic issue(input logic we, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [3:0] tag, input logic [31:0] exp);
    int n = 0;
    bus.req_valid = 1; bus.req_we = we; bus.req_addr = a;
    bus.req_wdata = d; bus.req_be = be; bus.req_tag = tag;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      total++;
      $display("FAIL req_timeout: got req_ready 0 expected 1 for addr %0h", a);
    end else begin
      @(posedge clk);
      if (!we) exp_q.push_back('{rdata: exp, tag: tag});
    end
    #1 bus.req_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain_pending", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int acc, c0, a;
    bit hs;
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_be = 0; bus.req_tag = 0; bus.rsp_ready = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_csb", csb, 1);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
    end
    bus.req_valid = 0;
    #2 rst_n = 1;
    @(posedge clk); #1;
    issue(1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    issue(0, 8'h10, 0, 0, 3, 32'hDEADBEEF);
    @(negedge clk); chk("lat_n1_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk); chk("lat_n2_rsp_valid", bus.rsp_valid, 1);
    drain();
    issue(1, 8'h20, 32'hFFFFFFFF, 4'hF, 0, 0);
    issue(1, 8'h20, 32'h11223344, 4'b0101, 0, 0);
    issue(0, 8'h20, 0, 0, 5, 32'hFF22FF44);
    drain();
    bus.rsp_ready = 0;
    bus.req_valid = 1; bus.req_we = 0; a = 0; acc = 0;
    repeat (8) begin
      bus.req_addr = 8'(a); bus.req_tag = 4'(a);
      @(negedge clk); hs = bus.req_ready;
      @(posedge clk);
      if (hs) begin exp_q.push_back('{rdata: init_val(a), tag: 4'(a)}); a++; acc++; end
      #1;
    end
    chk("credit_accepted", acc, 4);
    @(negedge clk); chk("credit_read_blocked", bus.req_ready, 0);
    #1 bus.req_we = 1; bus.req_addr = 8'h30; bus.req_wdata = 32'h30303030; bus.req_be = 4'hF;
    #1 chk("credit_write_ok", bus.req_ready, 1);
    @(posedge clk); #1 bus.req_valid = 0; bus.rsp_ready = 1;
    issue(0, 8'h04, 0, 0, 4, init_val(4));
    issue(0, 8'h05, 0, 0, 5, init_val(5));
    issue(0, 8'h30, 0, 0, 6, 32'h30303030);
    drain();
    c0 = cyc;
    for (int i = 0; i < 16; i++) issue(0, 8'(i), 0, 0, 4'(i), init_val(i));
    chk("b2b_cycles", cyc - c0, 16);
    drain();
    bus.rsp_ready = 0;
    for (int i = 0; i < 4; i++) issue(0, 8'(8 + i), 0, 0, 4'(i), init_val(8 + i));
    chk("pre_rst_rsp_valid", bus.rsp_valid, 1);
    #2 rst_n = 0;
    #1 chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_req_ready", bus.req_ready, 0);
    exp_q.delete();
    bus.rsp_ready = 1;
    #2 rst_n = 1;
    repeat (4) begin @(negedge clk); chk("post_rst_rsp_valid", bus.rsp_valid, 0); end
    @(posedge clk); #1;
    issue(0, 8'h07, 0, 0, 9, init_val(7));
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
